// File: rtl/ds_rom_table_seq_if.sv
// ds_rom_table_seq_if: loader and byte-server bus of the
// ROM-code table; master drives requests, slave answers.
interface ds_rom_table_seq_if #(
   parameter int DEV_W = 2
);
   logic             ld_start;
   logic [DEV_W-1:0] ld_dev;
   logic             ld_en;
   logic [7:0]       ld_byte;
   logic             ld_done;
   logic             ld_ok;
   logic             frame_start;
   logic             byte_req;
   logic [7:0]       byte_out;
   logic             byte_vld;
   logic             byte_last;
   logic             next_dev;
   logic [DEV_W-1:0] device;
   logic             dev_valid;
   logic             none_valid;

   modport master (
      output ld_start, ld_dev, ld_en, ld_byte,
      output frame_start, byte_req, next_dev,
      input  ld_done, ld_ok, byte_out, byte_vld,
      input  byte_last, device, dev_valid, none_valid
   );

   modport slave (
      input  ld_start, ld_dev, ld_en, ld_byte,
      input  frame_start, byte_req, next_dev,
      output ld_done, ld_ok, byte_out, byte_vld,
      output byte_last, device, dev_valid, none_valid
   );
endinterface

// File: rtl/ds_rom_table_seq.sv
// ds_rom_table_seq: 1-Wire ROM-code table with CRC-8 check,
// LSB-first byte server and round-robin device sequencer.
module ds_rom_table_seq #(
   parameter int         NUM_DEV      = 4,
   parameter int         CHECK_FAMILY = 1,
   parameter logic [7:0] FAMILY       = 8'h28,
   parameter int         SKIP_INVALID = 1,
   localparam int        DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
   input logic              clk,
   input logic              rst_n,
   ds_rom_table_seq_if.slave bus
);

   typedef enum logic {IDLE, LOAD} ld_state_t;

   ld_state_t        state, state_nxt;
   logic [7:0]       tbl [NUM_DEV][8];
   logic [NUM_DEV-1:0] valid;
   logic [DEV_W-1:0] idx;
   logic [DEV_W-1:0] device, dev_nxt;
   logic [2:0]       cnt;
   logic [7:0]       crc, crc_upd;
   logic [3:0]       ptr;
   logic             start, wr, fin, ok;
   logic             ld_done, ld_ok;
   logic [7:0]       byte_out;
   logic             byte_vld, byte_last;
   logic             issue;

   function automatic logic [DEV_W-1:0] wrap_add(
      input logic [DEV_W-1:0] d, input int i);
      int s;
      s = int'(d) + i;
      if (s >= NUM_DEV) s = s - NUM_DEV;
      return DEV_W'(s);
   endfunction

   // Out-of-range indices are ignored so the table is never
   // addressed beyond NUM_DEV-1.
   assign start = bus.ld_start && (int'(bus.ld_dev) < NUM_DEV);

   // Dallas CRC-8 (reflected 0x8C) folded over one byte.
   always_comb begin
      crc_upd = crc ^ bus.ld_byte;
      for (int b = 0; b < 8; b++) begin
         crc_upd = crc_upd[0] ? ((crc_upd >> 1) ^ 8'h8C)
                              : (crc_upd >> 1);
      end
   end

   // Loader next-state and write strobes.
   always_comb begin
      state_nxt = state;
      wr        = 1'b0;
      fin       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            if (start) begin
               state_nxt = LOAD;
            end else if (bus.ld_en) begin
               wr = 1'b1;
               if (cnt == 3'd7) begin
                  fin       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ok = (crc_upd == 8'h00) &&
               ((CHECK_FAMILY == 0) || (tbl[idx][0] == FAMILY));

   // Loader state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Table, CRC accumulator and valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         cnt     <= '0;
         crc     <= '0;
         valid   <= '0;
         ld_done <= 1'b0;
         ld_ok   <= 1'b0;
         for (int d = 0; d < NUM_DEV; d++)
            for (int b = 0; b < 8; b++)
               tbl[d][b] <= '0;
      end else begin
         ld_done <= fin;
         ld_ok   <= fin & ok;
         if (start) begin
            idx               <= bus.ld_dev;
            cnt               <= '0;
            crc               <= '0;
            valid[bus.ld_dev] <= 1'b0;
         end else if (wr) begin
            tbl[idx][cnt] <= bus.ld_byte;
            crc           <= crc_upd;
            cnt           <= cnt + 3'd1;
         end
         if (fin) valid[idx] <= ok;
      end
   end

   // Next device: nearest valid index above the current one,
   // wrapping; the current device is kept if nothing else is.
   always_comb begin
      dev_nxt = device;
      if (SKIP_INVALID == 0) begin
         dev_nxt = wrap_add(device, 1);
      end else begin
         for (int i = NUM_DEV - 1; i >= 1; i--)
            if (valid[wrap_add(device, i)])
               dev_nxt = wrap_add(device, i);
      end
   end

   // frame_start beats byte_req; pointer parks at 8.
   assign issue = bus.byte_req && !bus.frame_start && !ptr[3];

   // Byte server and device register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         byte_out  <= '0;
         byte_vld  <= 1'b0;
         byte_last <= 1'b0;
         device    <= '0;
      end else begin
         byte_vld  <= 1'b0;
         byte_last <= 1'b0;
         if (issue) begin
            byte_out  <= tbl[device][ptr[2:0]];
            byte_vld  <= 1'b1;
            byte_last <= (ptr == 4'd7);
            ptr       <= ptr + 4'd1;
         end
         if (bus.frame_start || bus.next_dev) ptr <= '0;
         if (bus.next_dev) device <= dev_nxt;
      end
   end

   assign bus.ld_done    = ld_done;
   assign bus.ld_ok      = ld_ok;
   assign bus.byte_out   = byte_out;
   assign bus.byte_vld   = byte_vld;
   assign bus.byte_last  = byte_last;
   assign bus.device     = device;
   assign bus.dev_valid  = valid[device];
   assign bus.none_valid = ~|valid;

endmodule

// File: tb/tb_ds_rom_table_seq.sv
// tb_ds_rom_table_seq: three configurations driven in lockstep;
// load/advance tables plus a byte-server scoreboard.
module tb_ds_rom_table_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ds_rom_table_seq_if #(.DEV_W(2)) b0 ();
   ds_rom_table_seq_if #(.DEV_W(2)) b1 ();
   ds_rom_table_seq_if #(.DEV_W(2)) b2 ();

   ds_rom_table_seq #(.NUM_DEV(4), .CHECK_FAMILY(1),
      .FAMILY(8'h28), .SKIP_INVALID(1))
   u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

   ds_rom_table_seq #(.NUM_DEV(4), .CHECK_FAMILY(0),
      .FAMILY(8'h28), .SKIP_INVALID(0))
   u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   ds_rom_table_seq #(.NUM_DEV(3), .CHECK_FAMILY(0),
      .FAMILY(8'h28), .SKIP_INVALID(1))
   u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

   assign b1.ld_start    = b0.ld_start;
   assign b1.ld_dev      = b0.ld_dev;
   assign b1.ld_en       = b0.ld_en;
   assign b1.ld_byte     = b0.ld_byte;
   assign b1.frame_start = b0.frame_start;
   assign b1.byte_req    = b0.byte_req;
   assign b1.next_dev    = b0.next_dev;
   assign b2.ld_start    = b0.ld_start;
   assign b2.ld_dev      = b0.ld_dev;
   assign b2.ld_en       = b0.ld_en;
   assign b2.ld_byte     = b0.ld_byte;
   assign b2.frame_start = b0.frame_start;
   assign b2.byte_req    = b0.byte_req;
   assign b2.next_dev    = b0.next_dev;

   typedef struct {
      logic [1:0]  dev;
      logic [63:0] code;
      logic        fix;
      logic [2:0]  ok;
   } ld_rec_t;

   typedef struct {
      logic [1:0] d0;
      logic [1:0] d1;
      logic [1:0] d2;
   } st_rec_t;

   typedef struct {
      logic [7:0] b;
      logic       last;
   } exp_t;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   exp_t q[$];
   logic [7:0] shadow [4][8];
   ld_rec_t lt [5];
   st_rec_t st [7];

   task automatic check(input string name,
      input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] crc8(input logic [55:0] d);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < 7; k++) begin
         c = c ^ d[8*k +: 8];
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
      end
      return c;
   endfunction

   task automatic do_load(input ld_rec_t r);
      logic [63:0] c;
      c = r.code;
      if (r.fix) c[63:56] = crc8(c[55:0]);
      b0.ld_start = 1'b1;
      b0.ld_dev   = r.dev;
      tick();
      b0.ld_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b0.ld_en   = 1'b1;
         b0.ld_byte = c[8*i +: 8];
         shadow[r.dev][i] = c[8*i +: 8];
         tick();
         if (i < 7) check("ld_done_early", b0.ld_done, 0);
      end
      b0.ld_en = 1'b0;
      check("ld_done", b0.ld_done, 1);
      check("ld_ok_u0", b0.ld_ok, r.ok[0]);
      check("ld_ok_u1", b1.ld_ok, r.ok[1]);
      check("ld_ok_u2", b2.ld_ok, r.ok[2]);
      b0.ld_en   = 1'b1;
      b0.ld_byte = 8'hEE;
      tick();
      b0.ld_en = 1'b0;
      check("ld_done_pulse", b0.ld_done, 0);
   endtask

   task automatic step(input st_rec_t s);
      b0.next_dev = 1'b1;
      tick();
      b0.next_dev = 1'b0;
      check("dev_u0", b0.device, s.d0);
      check("dev_u1", b1.device, s.d1);
      check("dev_u2", b2.device, s.d2);
      check("dev_valid_u0", b0.dev_valid, 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && b0.byte_vld) begin
         pulses++;
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL byte_unexpected: got %0h, want none",
                     b0.byte_out);
         end else begin
            e = q.pop_front();
            check("byte_out", b0.byte_out, e.b);
            check("byte_last", b0.byte_last, e.last);
         end
      end
   end

   initial begin
      b0.ld_start = 0; b0.ld_dev = 0; b0.ld_en = 0;
      b0.ld_byte = 0; b0.frame_start = 0;
      b0.byte_req = 0; b0.next_dev = 0;

      lt[0] = '{2'd1, 64'hA200000001B81C02, 1'b0, 3'b110};
      lt[1] = '{2'd1, 64'hA300000001B81C02, 1'b0, 3'b000};
      lt[2] = '{2'd0, 64'h0066554433221128, 1'b1, 3'b111};
      lt[3] = '{2'd2, 64'h00FFEEDDCCBBAA28, 1'b1, 3'b111};
      lt[4] = '{2'd1, 64'h0006050403020128, 1'b1, 3'b111};
      st[0] = '{2'd2, 2'd1, 2'd2};
      st[1] = '{2'd0, 2'd2, 2'd0};
      st[2] = '{2'd2, 2'd3, 2'd2};
      st[3] = '{2'd0, 2'd0, 2'd0};
      st[4] = '{2'd1, 2'd1, 2'd1};
      st[5] = '{2'd2, 2'd2, 2'd2};
      st[6] = '{2'd0, 2'd3, 2'd0};

      tick();
      tick();
      check("rst_byte_out", b0.byte_out, 0);
      check("rst_byte_vld", b0.byte_vld, 0);
      check("rst_byte_last", b0.byte_last, 0);
      check("rst_ld_done", b0.ld_done, 0);
      check("rst_ld_ok", b0.ld_ok, 0);
      check("rst_device", b0.device, 0);
      check("rst_dev_valid", b0.dev_valid, 0);
      check("rst_none_valid", b0.none_valid, 1);

      rst_n = 1'b1;
      tick();
      b0.next_dev = 1'b1;
      tick();
      b0.next_dev = 1'b0;
      check("nv_hold_u0", b0.device, 0);
      check("nv_plain_u1", b1.device, 1);
      check("nv_hold_u2", b2.device, 0);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) do_load(lt[i]);
      check("none_valid_clr", b0.none_valid, 0);
      for (int s = 0; s < 3; s++) step(st[s]);
      do_load(lt[4]);
      for (int s = 3; s < 7; s++) step(st[s]);

      b0.frame_start = 1'b1;
      tick();
      b0.frame_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         b0.byte_req = 1'b1;
         if (i < 8) q.push_back('{shadow[0][i], (i == 7)});
         tick();
      end
      b0.byte_req = 1'b0;
      tick();
      tick();
      check("pulses_frame", pulses, 8);

      b0.frame_start = 1'b1;
      b0.byte_req    = 1'b1;
      tick();
      b0.frame_start = 1'b0;
      b0.byte_req    = 1'b0;
      tick();
      check("fs_wins", pulses, 8);
      b0.byte_req = 1'b1;
      q.push_back('{shadow[0][0], 1'b0});
      tick();
      b0.byte_req = 1'b0;
      tick();
      check("ptr_after_fs", pulses, 9);

      q.push_back('{shadow[0][1], 1'b0});
      b0.next_dev = 1'b1;
      b0.byte_req = 1'b1;
      tick();
      b0.next_dev = 1'b0;
      b0.byte_req = 1'b0;
      check("nd_req_dev", b0.device, 1);
      b0.byte_req = 1'b1;
      q.push_back('{shadow[1][0], 1'b0});
      tick();
      b0.byte_req = 1'b0;
      tick();
      tick();
      check("pulses_total", pulses, 11);
      check("queue_empty", q.size(), 0);

      b0.ld_start = 1'b1;
      b0.ld_dev   = 2'd1;
      tick();
      b0.ld_start = 1'b0;
      check("dev_valid_drop", b0.dev_valid, 0);
      b0.ld_en   = 1'b1;
      b0.ld_byte = 8'h55;
      tick();
      tick();
      b0.ld_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_device", b0.device, 0);
      check("arst_dev_valid", b0.dev_valid, 0);
      check("arst_none_u0", b0.none_valid, 1);
      check("arst_none_u1", b1.none_valid, 1);
      check("arst_byte_out", b0.byte_out, 0);
      check("arst_byte_vld", b0.byte_vld, 0);
      check("arst_ld_done", b0.ld_done, 0);
      tick();
      rst_n = 1'b1;
      tick();
      b0.next_dev = 1'b1;
      tick();
      b0.next_dev = 1'b0;
      check("post_rst_dev", b0.device, 0);
      b0.byte_req = 1'b1;
      q.push_back('{8'h00, 1'b0});
      tick();
      b0.byte_req = 1'b0;
      tick();
      tick();
      check("post_rst_queue", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
